reg_set_clear: RTL and testbench
================================

# reg_set_clear

Registered set/clear flag with clock and asynchronous reset. A `set` pulse drives the output high, a `clear` pulse drives it low, and the output holds its value between pulses. The packet-filter datapath uses it for sticky per-frame status. One example is tracking "current frame dropped": it is set by the drop request and cleared by the frame's `tlast`. Parameterized to a vector of independent bit-flags.

## Interface
- `WIDTH`, default 1: number of independent flag bits.
- `RESET_VALUE`, default all-zeros (`WIDTH` bits): value loaded into `q` while reset is asserted.
- `SET_PRIORITY`, default 0: resolves set and clear asserted on the same bit in the same cycle. 0 means clear wins; 1 means set wins.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `set` input `WIDTH`: per-bit set request, sampled at the rising edge of `clk`.
- `clear` input `WIDTH`: per-bit clear request, sampled at the rising edge of `clk`.
- `q` output `WIDTH`: registered flag value.
- Positional port order is fixed: `clk`, `reset`, `set`, `clear`, `q`.

## Operation
- Each bit `i` is an independent flop. The next-state rules per bit are:
  - `set[i]`=1, `clear[i]`=0: `q[i]` becomes 1.
  - `set[i]`=0, `clear[i]`=1: `q[i]` becomes 0.
  - Both 0: `q[i]` holds its value.
  - Both 1: `q[i]` becomes 1 if `SET_PRIORITY`=1, otherwise 0.
- Setting an already-set bit or clearing an already-clear bit has no side effects.
- There is no enable. `set` and `clear` are qualified only by the clock edge.
- The output is purely registered. There is no combinational path from `set` or `clear` to `q`.
- Reset:
  - `reset`=1 forces `q`=`RESET_VALUE` immediately, without waiting for a clock edge.
  - `q` holds `RESET_VALUE` for as long as reset is asserted, regardless of `set` and `clear`.
  - Reset may be asserted at any time, including mid-frame. Any pending set is discarded.
- After reset deasserts, the first rising edge evaluates `set` and `clear` normally.
- X or Z on `set` or `clear` outside reset is illegal. Simulation flags it with a bench assertion; synthesis behaviour is unspecified.

## Timing
- Latency: a request at rising edge N is visible on `q` just after edge N. It is observed by sampling logic at edge N+1.
- A single-cycle pulse on `set` produces `q`=1 persisting until a `clear` edge or reset.
- Back-to-back cycles:
  - set at N, clear at N+1 gives `q`: 1 after N, 0 after N+1.
  - clear at N, set at N+1 gives 0 then 1.
- Simultaneous set and clear: resolved within the same edge per `SET_PRIORITY`, with no intermediate glitch on `q`.
- Reset assertion is asynchronous.
- Reset deassertion must meet recovery/removal timing to `clk`. Integrating logic synchronizes the deassertion upstream; this block does not.
- `WIDTH`=1 is the primary configuration. All bits share clock and reset.

## Test plan
- Reset behaviour: hold `reset`=1 with `set`=1 for 3 cycles.
  - Required: `q`=0 throughout.
  - Release reset with `set`=`clear`=0: `q` stays 0.
- Set/hold/clear: pulse `set`=1 for 1 cycle, idle 5 cycles, pulse `clear`=1 for 1 cycle.
  - Required: `q`=1 from the edge after the set through the idle cycles, then `q`=0 after the clear edge.
- Simultaneous requests, default configuration: with `q`=0, drive `set`=`clear`=1 for one edge.
  - Required: `q`=0.
  - Repeat from `q`=1: `q`=0.
  - With `SET_PRIORITY`=1: `q`=1 in both cases.
- Asynchronous reset mid-operation: with `q`=1, assert `reset` between clock edges.
  - Required: `q`=0 before the next rising edge; `q` remains 0 after release until a new `set`.
- Back-to-back toggling: alternate `set` and `clear` every cycle for 8 cycles.
  - Required: `q` follows 1,0,1,0,… one edge behind the stimulus.
- Vector configuration: `WIDTH`=4, `RESET_VALUE`=4'b1010, then drive `set`=4'b0101, `clear`=4'b1000 for one edge.
  - Required: `q`=4'b1010 during reset and 4'b0111 after the edge.

Source files
------------

// File: rtl/reg_set_clear.sv
// Sticky per-bit set/clear flag register. Reset is asynchronous and active-high.
// SET_PRIORITY decides the winner when set and clear hit the same bit on one edge.
module reg_set_clear #(
   parameter int               WIDTH        = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter bit               SET_PRIORITY = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] clear,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;

   // Bits with neither request keep their value, so one expression covers all four cases.
   function automatic logic [WIDTH-1:0] next_flags(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] s,
      input logic [WIDTH-1:0] c
   );
      if (SET_PRIORITY)
         return (cur & ~c) | s;
      else
         return (cur | s) & ~c;
   endfunction

   always_comb begin
      w_next = next_flags(r_q, set, clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_q <= RESET_VALUE;
      else
         r_q <= w_next;
   end

   assign q = r_q;

endmodule

// File: tb/tb_reg_set_clear.sv
// Directed bench for reg_set_clear: default, set-priority and 4-bit vector instances.
module tb_reg_set_clear;

   logic       clk = 1'b0;
   logic       reset;
   logic       set1, clear1;
   logic [3:0] set4, clear4;
   logic       q0, q1;
   logic [3:0] q4;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   reg_set_clear u_dflt (
      .clk(clk), .reset(reset), .set(set1), .clear(clear1), .q(q0)
   );

   reg_set_clear #(.SET_PRIORITY(1'b1)) u_setp (
      .clk(clk), .reset(reset), .set(set1), .clear(clear1), .q(q1)
   );

   reg_set_clear #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_vec (
      .clk(clk), .reset(reset), .set(set4), .clear(clear4), .q(q4)
   );

   // Unknown request inputs outside reset are illegal.
   always @(posedge clk) begin
      if (reset === 1'b0) begin
         assert (!$isunknown({set1, clear1, set4, clear4}))
         else begin
            errors++;
            $error("FAIL xcheck set/clear unknown: %b %b %b %b", set1, clear1, set4, clear4);
         end
      end
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      set1   = 1'b1;
      clear1 = 1'b0;
      set4   = 4'b0000;
      clear4 = 4'b0000;

      // reset held with set asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_dflt", {3'b0, q0}, 4'b0000);
         chk("rst_setp", {3'b0, q1}, 4'b0000);
         chk("rst_vec", q4, 4'b1010);
      end
      reset = 1'b0;
      set1  = 1'b0;
      tick();
      chk("rel_dflt", {3'b0, q0}, 4'b0000);
      chk("rel_vec", q4, 4'b1010);

      // set, hold, clear
      set1 = 1'b1;
      tick();
      chk("set", {3'b0, q0}, 4'b0001);
      set1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold", {3'b0, q0}, 4'b0001);
      end
      clear1 = 1'b1;
      tick();
      chk("clear", {3'b0, q0}, 4'b0000);
      clear1 = 1'b0;

      // simultaneous set and clear from q=0
      set1   = 1'b1;
      clear1 = 1'b1;
      tick();
      chk("both0_dflt", {3'b0, q0}, 4'b0000);
      chk("both0_setp", {3'b0, q1}, 4'b0001);

      // simultaneous set and clear from q=1
      clear1 = 1'b0;
      tick();
      chk("pre_both1", {3'b0, q0}, 4'b0001);
      clear1 = 1'b1;
      tick();
      chk("both1_dflt", {3'b0, q0}, 4'b0000);
      chk("both1_setp", {3'b0, q1}, 4'b0001);
      set1 = 1'b0;
      tick();
      chk("clr_setp", {3'b0, q1}, 4'b0000);
      clear1 = 1'b0;

      // asynchronous reset between edges
      set1 = 1'b1;
      tick();
      chk("pre_async", {3'b0, q0}, 4'b0001);
      set1 = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_dflt", {3'b0, q0}, 4'b0000);
      chk("async_setp", {3'b0, q1}, 4'b0000);
      tick();
      reset = 1'b0;
      tick();
      chk("post_async", {3'b0, q0}, 4'b0000);
      tick();
      chk("post_async2", {3'b0, q0}, 4'b0000);

      // alternate set and clear every cycle
      for (int i = 0; i < 8; i++) begin
         set1   = (i % 2 == 0);
         clear1 = (i % 2 != 0);
         tick();
         chk("toggle", {3'b0, q0}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      set1   = 1'b0;
      clear1 = 1'b0;

      // vector instance: requests ignored in reset, applied on first edge after
      reset  = 1'b1;
      set4   = 4'b0101;
      clear4 = 4'b1000;
      tick();
      chk("vec_rst", q4, 4'b1010);
      reset = 1'b0;
      tick();
      chk("vec_edge", q4, 4'b0111);
      set4   = 4'b0000;
      clear4 = 4'b0000;
      tick();
      chk("vec_hold", q4, 4'b0111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
